tx_symbol_upsampler: RTL and testbench

// - Upstream feed of the TX pulse-shaping filter. Generates 4-ASK symbols from a PRBS15

---
 rtl/tx_symbol_upsampler_pkg.sv | 31 +++
 rtl/tx_symbol_upsampler_prbs15_2step.sv | 22 ++
 rtl/tx_symbol_upsampler.sv | 118 +++++++++++
 tb/tb_tx_symbol_upsampler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_symbol_upsampler_pkg.sv
// Shared constants for the TX symbol upsampler: 4-ASK output levels, mode
// encodings, PRBS15 taps and the Gray bit-pair to level map.
package tx_pkg;

  localparam logic signed [17:0] LEVEL_M3 = -18'sd98304;
  localparam logic signed [17:0] LEVEL_M1 = -18'sd32768;
  localparam logic signed [17:0] LEVEL_P1 = 18'sd32768;
  localparam logic signed [17:0] LEVEL_P3 = 18'sd98304;

  localparam logic [1:0] MODE_PRBS  = 2'b00;
  localparam logic [1:0] MODE_EXT   = 2'b01;
  localparam logic [1:0] MODE_CONST = 2'b10;
  localparam logic [1:0] MODE_IMP   = 2'b11;

  localparam int PRBS_TAP_A = 14;
  localparam int PRBS_TAP_B = 13;

  // Gray order: adjacent levels differ in one bit, so a one-level slip costs one bit error.
  function automatic logic signed [17:0] gray_map(input logic [1:0] bits);
    logic signed [17:0] level;
    case (bits)
      2'b00:   level = LEVEL_M3;
      2'b01:   level = LEVEL_M1;
      2'b11:   level = LEVEL_P1;
      2'b10:   level = LEVEL_P3;
      default: level = LEVEL_M3;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/tx_symbol_upsampler_prbs15_2step.sv
// Two PRBS15 steps per call: produces the symbol's bit pair (first step first)
// and the advanced state. Lockup handling lives in the parent.
module prbs15_2step
  import tx_pkg::*;
(
  input  logic [14:0] state,
  output logic [14:0] next_state,
  output logic        b1,
  output logic        b0
);

  logic [14:0] mid_s;

  // Chain two shift-and-feedback steps.
  always_comb begin
    b1         = state[PRBS_TAP_A] ^ state[PRBS_TAP_B];
    mid_s      = {state[13:0], b1};
    b0         = mid_s[PRBS_TAP_A] ^ mid_s[PRBS_TAP_B];
    next_state = {mid_s[13:0], b0};
  end

endmodule

// File: rtl/tx_symbol_upsampler.sv
// 4-ASK symbol source for the TX pulse-shaping filter: PRBS15 / external /
// constant / impulse symbols, Gray-mapped and zero-stuffed by UPSAMPLE.
module tx_symbol_upsampler
  import tx_pkg::*;
#(
  parameter int          UPSAMPLE  = 4,
  parameter logic [14:0] LFSR_SEED = 15'h7FFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [1:0]         ext_bits,
  output logic               ext_req,
  output logic               sym_strobe,
  output logic signed [17:0] x_out
);

  localparam int             PW         = $clog2(UPSAMPLE);
  localparam logic [PW-1:0]  PHASE_LAST = PW'(UPSAMPLE - 1);

  logic [PW-1:0]      phase_r;
  logic [PW-1:0]      phase_next_s;
  logic [14:0]        lfsr_r;
  logic [14:0]        lfsr_in_s;
  logic [14:0]        lfsr_next_s;
  logic [1:0]         mode_q_r;
  logic               imp_done_r;
  logic               imp_done_next_s;
  logic               sym_cycle_s;
  logic               prbs_b1_s;
  logic               prbs_b0_s;
  logic signed [17:0] x_next_s;

  assign sym_cycle_s = enable & (phase_r == {PW{1'b0}});
  assign ext_req     = sym_cycle_s & (mode == MODE_EXT);
  // An all-zero register would stick forever; restart from the seed instead.
  assign lfsr_in_s   = (lfsr_r == 15'd0) ? LFSR_SEED : lfsr_r;

  prbs15_2step u_prbs (
    .state      (lfsr_in_s),
    .next_state (lfsr_next_s),
    .b1         (prbs_b1_s),
    .b0         (prbs_b0_s)
  );

  // Phase counter wrap.
  always_comb begin
    if (phase_r == PHASE_LAST) begin
      phase_next_s = {PW{1'b0}};
    end else begin
      phase_next_s = phase_r + PW'(1);
    end
  end

  // Next output sample and impulse bookkeeping; mode is taken fresh at each symbol boundary.
  always_comb begin
    x_next_s        = 18'sd0;
    imp_done_next_s = imp_done_r;
    if (sym_cycle_s) begin
      case (mode)
        MODE_PRBS: begin
          x_next_s        = gray_map({prbs_b1_s, prbs_b0_s});
          imp_done_next_s = 1'b0;
        end
        MODE_EXT: begin
          x_next_s        = gray_map(ext_bits);
          imp_done_next_s = 1'b0;
        end
        MODE_CONST: begin
          x_next_s        = LEVEL_P3;
          imp_done_next_s = 1'b0;
        end
        MODE_IMP: begin
          if ((mode_q_r != MODE_IMP) || !imp_done_r) begin
            x_next_s = LEVEL_P3;
          end else begin
            x_next_s = 18'sd0;
          end
          imp_done_next_s = 1'b1;
        end
        default: begin
          x_next_s        = 18'sd0;
          imp_done_next_s = 1'b0;
        end
      endcase
    end else begin
      x_next_s        = 18'sd0;
      imp_done_next_s = imp_done_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r    <= {PW{1'b0}};
      lfsr_r     <= LFSR_SEED;
      mode_q_r   <= MODE_PRBS;
      imp_done_r <= 1'b0;
      x_out      <= 18'sd0;
      sym_strobe <= 1'b0;
    end else begin
      x_out      <= x_next_s;
      sym_strobe <= sym_cycle_s;
      if (enable) begin
        phase_r <= phase_next_s;
      end
      if (sym_cycle_s) begin
        mode_q_r   <= mode;
        imp_done_r <= imp_done_next_s;
        if (mode == MODE_PRBS) begin
          lfsr_r <= lfsr_next_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_symbol_upsampler.sv
// Directed bench for tx_symbol_upsampler: a cycle model built from a PRBS bit
// queue and a symbol/phase count is compared every cycle, plus literal pins.
module tb_tx_symbol_upsampler;

  localparam int          UPS  = 4;
  localparam logic [14:0] SEED = 15'h7FFF;

  logic               clk      = 1'b0;
  logic               reset    = 1'b0;
  logic               enable   = 1'b0;
  logic [1:0]         mode     = 2'b00;
  logic [1:0]         ext_bits = 2'b00;
  logic               ext_req;
  logic               sym_strobe;
  logic signed [17:0] x_out;

  int errors = 0;
  int checks = 0;

  tx_symbol_upsampler #(.UPSAMPLE(UPS), .LFSR_SEED(SEED)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .ext_bits   (ext_bits),
    .ext_req    (ext_req),
    .sym_strobe (sym_strobe),
    .x_out      (x_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase     = 0;
  int m_last_mode = 0;
  int exp_x       = 0;
  int exp_strobe  = 0;
  bit prbs_q[$];
  int syms[$];

  function automatic int level(input bit b1, input bit b0);
    if (!b1 && !b0) return -98304;
    if (!b1 &&  b0) return -32768;
    if ( b1 &&  b0) return 32768;
    return 98304;
  endfunction

  // Bit k of the PRBS is bit(k-15) xor bit(k-14); queue holds the last 15, oldest first.
  function automatic bit prbs_next();
    bit n;
    n = prbs_q[0] ^ prbs_q[1];
    void'(prbs_q.pop_front());
    prbs_q.push_back(n);
    return n;
  endfunction

  function automatic void prbs_init();
    prbs_q.delete();
    for (int i = 14; i >= 0; i--) prbs_q.push_back(SEED[i]);
  endfunction

  always @(posedge clk or negedge reset) begin
    bit b1, b0;
    if (!reset) begin
      m_phase = 0; m_last_mode = 0; exp_x = 0; exp_strobe = 0;
      prbs_init();
    end else begin
      exp_x = 0; exp_strobe = 0;
      if (enable) begin
        if (m_phase == 0) begin
          exp_strobe = 1;
          case (mode)
            2'b00: begin b1 = prbs_next(); b0 = prbs_next(); exp_x = level(b1, b0); end
            2'b01: exp_x = level(ext_bits[1], ext_bits[0]);
            2'b10: exp_x = 98304;
            default: exp_x = (m_last_mode != 3) ? 98304 : 0;
          endcase
          m_last_mode = int'(mode);
        end
        m_phase = (m_phase + 1) % UPS;
      end
    end
    #1;
    check("x_out", int'(x_out), exp_x);
    check("sym_strobe", int'(sym_strobe), exp_strobe);
    if (sym_strobe === 1'b1) syms.push_back(int'(x_out));
  end

  always @(negedge clk) begin
    #1;
    check("ext_req", int'(ext_req), int'(enable && m_phase == 0 && mode == 2'b01));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int sym_at(input int i);
    if (i < syms.size()) return syms[i];
    return -1;
  endfunction

  // From seed 7FFF the first 14 PRBS bits are 0 and bits 15,16 are 1,0.
  task automatic check_prbs8(input string name);
    check({name, "_count"}, syms.size(), 8);
    for (int i = 0; i < 7; i++) check({name, "_sym"}, sym_at(i), -98304);
    check({name, "_sym8"}, sym_at(7), 98304);
  endtask

  logic [1:0] pat [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         ext_lv[4] = '{-98304, -32768, 32768, 98304};

  initial begin
    int n0;
    bit pq[$];
    int first_ones;
    int zero_seen;
    int sum;
    bit n;

    // Impulse after reset release.
    reset = 1'b0; enable = 1'b1; mode = 2'b11;
    cyc(2);
    reset = 1'b1; syms.delete();
    cyc(12);
    check("imp_count", syms.size(), 3);
    check("imp_first", sym_at(0), 98304);
    check("imp_second", sym_at(1), 0);
    check("imp_third", sym_at(2), 0);

    // External bits through the Gray map.
    mode = 2'b01; syms.delete();
    for (int i = 0; i < 4; i++) begin
      ext_bits = pat[i];
      cyc(4);
    end
    check("ext_count", syms.size(), 4);
    for (int i = 0; i < 4; i++) check("ext_level", sym_at(i), ext_lv[i]);

    // PRBS from the seed.
    mode = 2'b00; syms.delete();
    cyc(32);
    check_prbs8("prbs");

    // Enable low at phase 2.
    cyc(2);
    n0 = syms.size();
    enable = 1'b0;
    cyc(7);
    check("hold_no_sym", syms.size(), n0);
    enable = 1'b1;
    cyc(2);
    check("resume_wait", syms.size(), n0);
    cyc(1);
    check("resume_sym", syms.size(), n0 + 1);
    check("resume_strobe", int'(sym_strobe), 1);

    // Mode change at phase 1 to constant, then back to PRBS.
    mode = 2'b10; syms.delete();
    cyc(3);
    check("const_wait", syms.size(), 0);
    cyc(1);
    check("const_count", syms.size(), 1);
    check("const_level", sym_at(0), 98304);
    mode = 2'b00;
    cyc(12);

    // Asynchronous reset mid-symbol while x_out carries a symbol.
    #2 reset = 1'b0;
    #1;
    check("async_x", int'(x_out), 0);
    check("async_strobe", int'(sym_strobe), 0);
    @(negedge clk);
    reset = 1'b1; syms.delete();
    cyc(32);
    check_prbs8("post_reset");

    // Model sanity: PRBS15 two-step period is 32767 and never reaches zero.
    for (int i = 14; i >= 0; i--) pq.push_back(SEED[i]);
    first_ones = 0; zero_seen = 0;
    for (int k = 1; k <= 32767; k++) begin
      for (int s = 0; s < 2; s++) begin
        n = pq[0] ^ pq[1];
        void'(pq.pop_front());
        pq.push_back(n);
      end
      sum = 0;
      for (int j = 0; j < 15; j++) sum += int'(pq[j]);
      if (sum == 0) zero_seen = 1;
      if (sum == 15 && first_ones == 0) first_ones = k;
    end
    check("model_period", first_ones, 32767);
    check("model_no_zero", zero_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
